// File: rtl/seg7_pkg.sv
// seg7_pkg: shared glyph table, slot width and slot-divider calculation for the 7-segment scan driver
package seg7_pkg;
  localparam int SLOT_BITS = 4;
  // Active-high glyphs, bit 0 = segment a ... bit 6 = segment g
  localparam logic [6:0] GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  function automatic int calc_div(input int clk_hz, input int frame_hz, input int digits);
    int d;
    d = clk_hz / (frame_hz * digits * (1 << SLOT_BITS));
    return (d < 1) ? 1 : d;
  endfunction
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: nibble to active-high 7-segment glyph
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  assign o_seg = GLYPHS[i_nib];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed multi-digit 7-segment scan driver with shadowed frame-synchronous updates.
// Define SEG7_BLINK_EN to add the per-digit Blink_mask input and the 256-frame blink phase.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int CLK_HZ         = 50000000,
  parameter int FRAME_HZ       = 1000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  En,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   Disp_data,
  input  logic [DIGITS-1:0]     Dp,
  input  logic [DIGITS-1:0]     Dig_mask,
`ifdef SEG7_BLINK_EN
  input  logic [DIGITS-1:0]     Blink_mask,
`endif
  input  logic                  Lzb,
  input  logic [3:0]            Bright,
  output logic                  Pending,
  output logic                  Frame_sync,
  output logic [DIGITS-1:0]     Sel,
  output logic [6:0]            Seg,
  output logic                  Seg_dp
);
  localparam int DIV = calc_div(CLK_HZ, FRAME_HZ, DIGITS);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic              SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [6:0]        SEG_OFF = {7{SEG_INV}};
  logic [DW-1:0]        r_div;
  logic [SLOT_BITS-1:0] r_slot;
  logic [IW-1:0]        r_idx;
  logic                 r_pending, r_fsync;
  logic [4*DIGITS-1:0]  r_sh_data, r_data;
  logic [DIGITS-1:0]    r_sh_dp, r_dp, r_sh_mask, r_mask;
  logic [DIGITS-1:0]    r_sel;
  logic [6:0]           r_seg;
  logic                 r_sdp;
  logic                 w_tick, w_slot_wrap, w_last, w_frame;
  logic [DIGITS-1:0]    w_zrun;
  logic [3:0]           w_nib;
  logic [6:0]           w_glyph;
  logic                 w_lead, w_blink_on, w_on, w_lit_seg, w_lit_dp;
  logic [DIGITS-1:0]    w_sel;
  assign w_tick      = r_div == DW'(DIV - 1);
  assign w_slot_wrap = w_tick && (r_slot == '1);
  assign w_last      = r_idx == IW'(DIGITS - 1);
  assign w_frame     = w_slot_wrap && w_last;
  // w_zrun[i] = every active nibble from i up to the top digit is zero
  always_comb begin
    logic z;
    z = 1'b1;
    w_zrun = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      z = z && (r_data[4*k +: 4] == 4'd0);
      w_zrun[k] = z;
    end
  end
  assign w_nib  = r_data[4*r_idx +: 4];
  assign w_lead = Lzb && (r_idx != '0) && w_zrun[r_idx];
  seg7_hex_decode u_dec (
    .i_nib (w_nib),
    .o_seg (w_glyph)
  );
`ifdef SEG7_BLINK_EN
  logic [DIGITS-1:0] r_sh_blink, r_blink;
  logic [7:0]        r_fcnt;
  logic              r_phase;
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_sh_blink <= '0;
      r_blink    <= '0;
      r_fcnt     <= '0;
      r_phase    <= 1'b1;
    end else begin
      if (Load) r_sh_blink <= Blink_mask;
      if (w_frame && r_pending) r_blink <= r_sh_blink;
      if (w_frame) r_fcnt <= r_fcnt + 1'b1;
      if (w_frame && r_fcnt == 8'hFF) r_phase <= ~r_phase;
    end
  end
  assign w_blink_on = r_phase || !r_blink[r_idx];
`else
  assign w_blink_on = 1'b1;
`endif
  assign w_on      = En && r_mask[r_idx] && (r_slot <= Bright) && w_blink_on;
  assign w_lit_seg = w_on && !w_lead;
  assign w_lit_dp  = w_on && r_dp[r_idx];
  assign w_sel     = (w_lit_seg || w_lit_dp) ? (DIGITS'(1) << r_idx) : '0;
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_div     <= '0;
      r_slot    <= '0;
      r_idx     <= '0;
      r_pending <= 1'b0;
      r_fsync   <= 1'b0;
      r_sh_data <= '0;
      r_sh_dp   <= '0;
      r_sh_mask <= '0;
      r_data    <= '0;
      r_dp      <= '0;
      r_mask    <= '0;
      r_sel     <= SEL_OFF;
      r_seg     <= SEG_OFF;
      r_sdp     <= SEG_INV;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) r_slot <= r_slot + 1'b1;
      if (w_slot_wrap) r_idx <= w_last ? '0 : r_idx + 1'b1;
      r_fsync   <= w_frame;
      r_pending <= Load || (r_pending && !w_frame);
      if (Load) begin
        r_sh_data <= Disp_data;
        r_sh_dp   <= Dp;
        r_sh_mask <= Dig_mask;
      end
      // commit reads the shadow before a coincident Load overwrites it
      if (w_frame && r_pending) begin
        r_data <= r_sh_data;
        r_dp   <= r_sh_dp;
        r_mask <= r_sh_mask;
      end
      r_sel <= w_sel ^ SEL_OFF;
      r_seg <= (w_lit_seg ? w_glyph : 7'd0) ^ SEG_OFF;
      r_sdp <= w_lit_dp ^ SEG_INV;
    end
  end
  assign Pending    = r_pending;
  assign Frame_sync = r_fsync;
  assign Sel        = r_sel;
  assign Seg        = r_seg;
  assign Seg_dp     = r_sdp;
endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Parametrised multi-digit 7-segment scan driver; next generation of the fixed 8-digit HXE8 display driver, and its drop-in replacement.
- Sits beside the soft-CPU system; fed by the seg7 data and enable PIOs.
- Adds configurable digit count, tear-free shadow load, per-digit enable mask, decimal points, leading-zero blanking, PWM brightness and a frame-sync output.

Parameters:
DIGITS, 8, number of multiplexed digits (1..16)
CLK_HZ, 50000000, Clk frequency in Hz
FRAME_HZ, 1000, full-frame refresh rate in Hz
SEG_ACTIVE_LOW, 1, 1 = Seg/Seg_dp drive 0 to light a segment
SEL_ACTIVE_LOW, 1, 1 = Sel drives 0 to enable a digit

Ports:
Clk  input  1  system clock
Rst  input  1  synchronous reset, active-high
En  input  1  display enable; 0 blanks all outputs, scanning continues
Load  input  1  one-cycle strobe; captures Disp_data/Dp/Dig_mask into shadow registers
Disp_data  input  4*DIGITS  hex nibbles; nibble i shown on digit i (digit 0 = least significant)
Dp  input  DIGITS  decimal point per digit
Dig_mask  input  DIGITS  1 = digit enabled
Lzb  input  1  leading-zero blanking enable
Bright  input  4  brightness level 0..15
Pending  output  1  shadow loaded, not yet committed
Frame_sync  output  1  one-cycle pulse at every commit point
Sel  output  DIGITS  digit select, one-hot when active
Seg  output  7  segments; Seg[0]=a ... Seg[6]=g
Seg_dp  output  1  decimal-point segment

Behaviour:
- Timing
  - Slot divider DIV = CLK_HZ/(FRAME_HZ*DIGITS*16), minimum 1.
  - Slot counter 0..15 advances every DIV clocks.
  - Digit period = 16 slots. Digit index 0..DIGITS-1 advances at slot wrap and wraps to 0.
  - Frame boundary = digit index wrapping from DIGITS-1 to 0.
- Commit
  - At a frame boundary with Pending=1: shadow is copied to the active registers, Pending clears, and Frame_sync pulses in the same cycle.
  - Frame_sync also pulses at every frame boundary when nothing is pending.
- Load
  - Load=1 captures into shadow and sets Pending next cycle.
  - Load while Pending overwrites the shadow (last write wins).
  - Load coinciding with a commit cycle: the commit uses the old shadow, the new data enters shadow, Pending stays 1.
- Blanking
  - Digit i is dark if Dig_mask[i]=0, or En=0, or it is lead-blanked.
  - Lead-blanked: Lzb=1 and active nibbles i..DIGITS-1 all zero, with i>0. Digit 0 is never lead-blanked.
  - Dp still lights on a lead-blanked digit if Dp[i]=1; Dp does not light on a masked digit.
- Brightness
  - Current digit is lit only while slot <= Bright, giving (Bright+1)/16 duty.
  - Bright is sampled live, not shadowed.
- Decode: standard hex glyphs 0-9, A, b, C, d, E, F. Example: active-high 0=7'h3F, 8=7'h7F, F=7'h71; inverted when SEG_ACTIVE_LOW.
- Outputs
  - Sel, Seg and Seg_dp are registered, updating one clock after the index/slot change.
  - Dark means Sel all inactive and Seg/Seg_dp inactive.
- Reset (Rst=1, synchronous)
  - Counters, index, active and shadow registers cleared; Pending=0; Frame_sync=0.
  - Sel, Seg and Seg_dp inactive (all 1s when active-low).
  - Reset mid-frame discards any pending shadow.

Optional Feature:
SEG7_BLINK_EN
- Defined: adds input Blink_mask[DIGITS], shadowed and committed like Dp. A blink phase toggles every 256 frames. Masked digits are dark during the off phase; the phase register resets to on.
- Undefined: no Blink_mask port and no blink logic.

Decomposition:
- Package seg7_pkg: glyph constant table (16 x 7-bit, active-high), SLOT_BITS=4, and a DIV computation function.
- Sub-module seg7_hex_decode: combinational nibble to active-high 7-bit glyph; polarity is applied in the parent.

Test Plan:
Use sim parameters CLK_HZ=12800, FRAME_HZ=100, DIGITS=8, so DIV=1, 16 clocks per digit and 128 clocks per frame.
- Reset, then Load Disp_data=32'h1234ABCD, Dig_mask=8'hFF, Bright=15, En=1:
  - Pending=1 until the next frame boundary; Frame_sync pulses there.
  - Next frame shows digit 0 Seg=~7'h5E ('d') with Sel=8'hFE, and digit 7 Seg=~7'h06 ('1') with Sel=8'h7F.
- Data 32'h00000050, Lzb=1, Dp=8'h80: digits 7..2 have Sel inactive except digit 7 (Dp only, Seg=7'h7F, Seg_dp=0); digits 1 and 0 show 5 and 0.
- Bright=3: each digit lit exactly 4 of 16 clocks. Bright=0: 1 of 16.
- Two Loads (32'h11111111 then 32'h22222222) within one frame: only 2s appear, 1s never displayed.
- Load on the exact commit cycle: old shadow committed, Pending remains 1, new data displayed one frame later.
- Rst asserted mid-frame with Pending=1: next cycle Pending=0, Sel=8'hFF, Seg=7'h7F; after release the display stays blank (data 0 shows '0' only on enabled digits) and no stale commit occurs.
